lifo_arbiter: RTL
=================

# lifo_arbiter

Round-robin controller that shares one last-in-first-out stack between `NUM_REQ` requesters. Each requester issues push or pop transactions over a valid/ready handshake. The arbiter grants at most one eligible transaction per cycle and applies it to an internal stack core. Pop data returns on a shared response channel tagged with the requester index.

## Interface
- `DATA_WIDTH`, 8, width of one stack entry
- `DEPTH`, 8, number of stack entries (≥2)
- `NUM_REQ`, 4, number of requesters (≥2)

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in `NUM_REQ`: per-requester transaction request
- `req_op` in `NUM_REQ`: per-requester operation, 1 = push, 0 = pop
- `req_data` in `NUM_REQ*DATA_WIDTH`: push data; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready` out `NUM_REQ`: one-hot grant, combinational; transfer occurs when `req_valid[i] && req_ready[i]`
- `rsp_valid` out 1: pop data valid, one-cycle pulse
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that owns `rsp_data`
- `rsp_data` out `DATA_WIDTH`: popped entry
- `count` out `$clog2(DEPTH+1)`: current occupancy
- `full` out 1: `count == DEPTH`
- `empty` out 1: `count == 0`

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and either (push and not `full`) or (pop and not `empty`).
- Ineligible requests are not granted and simply wait. A pop on empty or push on full is never executed and never errors.
- Arbitration: round-robin with priority pointer `ptr`.
  - Grant the first eligible index scanning `ptr, ptr+1, … NUM_REQ-1, 0, …` (mod `NUM_REQ`).
  - On a grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - With no grant, `ptr` holds.
- At most one `req_ready` bit is high per cycle. It is zero when nothing is eligible.
- Push grant: write `req_data[i]` at index `count`, then `count <= count+1`.
- Pop grant: read entry `count-1`, then `count <= count-1`, and register the response (`rsp_data`, `rsp_id <= i`, `rsp_valid <= 1`).
- No-grant cycle: `count` holds and `rsp_valid <= 0`.
- Every push/pop is counted exactly once per granted handshake. A request held high across cycles produces one operation per grant, with no edge detection.
- Fairness: a continuously eligible requester is granted within `NUM_REQ` cycles.
- `full`/`empty` are decoded combinationally from registered `count`. They reflect state after the last edge.

## Timing
- Reset (async assert, sync-safe release):
  - `count=0`, `ptr=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`
  - therefore `empty=1`, `full=0`, `req_ready=0`
  - Memory is not cleared. Entries at or above `count` are never observable.
- Grant latency: 0 cycles. `req_ready` is combinational from `req_valid`, `req_op`, `count` and `ptr`.
- Push visibility: a pop granted in the cycle after a push returns that pushed value.
- Pop latency: `rsp_valid` asserts exactly 1 cycle after the granting edge's cycle, and lasts 1 cycle. There is no response backpressure.
- Back-to-back: one operation per cycle, sustained.
  - Push when `count==DEPTH-1` sets `full` on the next cycle.
  - Push requests are then ineligible; pops remain eligible.
- Reset mid-operation: any pending response is dropped and `rsp_valid` is forced low immediately.

## Structure
- Package `lifo_arbiter_pkg`: constants `OP_POP=1'b0`, `OP_PUSH=1'b1`, plus a function returning the round-robin winner index from an eligibility vector and pointer.
- Sub-module `lifo_core`: holds the memory array and the `count` register. Ports: `push`, `pop`, `wdata`, `rdata` (registered), `count`. It asserts neither push and pop together, nor illegal operations; legality is the arbiter's responsibility.
- Top-level `lifo_arbiter`: holds eligibility, the round-robin pointer, grant decode, and response registers (`rsp_id`).

## Test plan
- Reset: assert `reset` low mid-stream with `count=3` → `count=0`, `empty=1`, `rsp_valid=0` immediately; after release, a pop request gets no grant.
- Single requester: req0 pushes 0x11, 0x22, 0x33 on consecutive cycles, then pops three times → `rsp_data` returns 0x33, 0x22, 0x11, each with `rsp_id=0`, one cycle after its grant.
- Round-robin: all four requesters hold push valid from reset → grants in order 0,1,2,3,0…; then stack `full` after 8 grants, and `req_ready=0` for all.
- Full/empty guard with a mixed mix: stack full, req1 push and req2 pop valid with `ptr=1` → req2 granted; `count` goes 8→7 and `full` deasserts the next cycle.
- Empty pop: `empty=1`, req3 pops and req0 pushes 0xA5 in the same cycle → req0 granted. Next cycle req3 is granted and receives 0xA5 with `rsp_id=3`.
- Fairness: req0 continuously valid while req1–3 toggle randomly for 500 cycles → no requester waits more than 4 cycles while eligible, and the occupancy model matches `count` every cycle.

Source files
------------

// File: rtl/lifo_arbiter_pkg.sv
// Shared constants and the round-robin winner helper for the LIFO arbiter.
package lifo_arbiter_pkg;

    localparam logic OP_POP  = 1'b0;
    localparam logic OP_PUSH = 1'b1;

    // Widest requester vector the winner helper accepts.
    localparam int MAX_REQ = 32;

    // Index of the first set bit in elig scanning ptr, ptr+1, ... (mod n).
    // Walking the offsets from last to first lets the nearest hit win
    // without an early exit. Returns 0 when nothing is set; callers gate
    // with their own "any eligible" term.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] elig,
                                   input int                 ptr,
                                   input int                 n);
        int idx;
        int win;
        win = 0;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (elig[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/lifo_core.sv
// Stack storage plus occupancy register. The caller guarantees push and
// pop are exclusive and never applied on full/empty respectively.
module lifo_core #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic [CW-1:0]         top_idx;

    // Entry currently on top of the stack (only meaningful when non-empty).
    assign top_idx = count_q - CW'(1);

    // Occupancy next-state: one step up on push, one step down on pop.
    always_comb begin
        count_d = count_q;
        if (push)     count_d = count_q + CW'(1);
        else if (pop) count_d = count_q - CW'(1);
    end

    // Occupancy and registered read data; reset clears both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            count_q <= count_d;
            if (pop) rdata_q <= mem_q[top_idx[AW-1:0]];
        end
    end

    // Storage is left uninitialised; slots at or above count are never read.
    always_ff @(posedge clk) begin
        if (push) mem_q[count_q[AW-1:0]] <= wdata;
    end

    assign rdata = rdata_q;
    assign count = count_q;

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO between NUM_REQ requesters.
// One eligible push/pop is granted per cycle; pops answer one cycle later
// on a shared response channel tagged with the requester index.
module lifo_arbiter
    import lifo_arbiter_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    parameter  int NUM_REQ    = 4,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [IW-1:0]                 rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty
);

    logic [NUM_REQ-1:0]    elig;
    logic [MAX_REQ-1:0]    elig_ext;
    logic                  any_elig;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         ptr_d;
    logic                  do_push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rsp_valid_q;
    logic [IW-1:0]         rsp_id_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A request is eligible only if its operation is legal right now.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && ((req_op[i] == OP_PUSH) ? !full : !empty);
        end
    end

    // Winner selection, one-hot grant and the operation it drives into the core.
    always_comb begin
        elig_ext                = '0;
        elig_ext[NUM_REQ-1:0]   = elig;
        any_elig                = |elig;
        win_idx                 = IW'(rr_pick(elig_ext, int'(ptr_q), NUM_REQ));
        req_ready               = '0;
        if (any_elig) req_ready[win_idx] = 1'b1;
        do_push                 = any_elig && (req_op[win_idx] == OP_PUSH);
        do_pop                  = any_elig && (req_op[win_idx] == OP_POP);
        wdata                   = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
        ptr_d                   = ptr_q;
        if (any_elig) begin
            ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    // Priority pointer and response tag/valid; reset drops any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= do_pop;
            if (do_pop) rsp_id_q <= win_idx;
        end
    end

    lifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (wdata),
        .rdata (rsp_data),
        .count (count)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

endmodule
